// File: rtl/register_checkpoint_stack.sv
// ---------------------------------------------------------------------------
// register_checkpoint_stack
//
// Stores register-file checkpoints for speculative branch recovery. Each
// predicted branch allocates one full architectural register snapshot, in
// program order, into a circular buffer. The snapshots are released
// oldest-first:
//   - When the oldest branch resolves correctly, its snapshot is released.
//   - When the oldest branch mispredicts, its snapshot is returned on
//     restore_regs one cycle later, and the whole buffer is flushed.
// A writeback presented in the allocation cycle is merged into the captured
// snapshot. This lets the hazard unit allocate without waiting a cycle.
//
// Ports
//   clk, rst        sole clock; synchronous active-high reset
//   regs_in         current register file contents (NUM_REGS x DATA_WIDTH)
//   wb_en/addr/data same-cycle writeback merged into a new snapshot
//   alloc_req       take a checkpoint for a new predicted branch
//   alloc_ready     space available (= !full)
//   alloc_tag       tag the next accepted allocation receives
//   resolve_ok      oldest branch correct: release its checkpoint
//   resolve_bad     oldest branch mispredicted: restore it and flush all
//   restore_valid   one-cycle pulse, restore_regs/restore_tag valid
//   restore_regs    restored register image (holds after the pulse)
//   restore_tag     tag of the restored checkpoint
//   count           live checkpoints
//   full, empty     count == NUM_CKPT, count == 0
//   err             one-cycle pulse after a protocol violation
// ---------------------------------------------------------------------------
module register_checkpoint_stack #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_CKPT   = 4,
   parameter int TAG_W      = $clog2(NUM_CKPT)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_in,
   input  logic                                wb_en,
   input  logic [$clog2(NUM_REGS)-1:0]         wb_addr,
   input  logic [DATA_WIDTH-1:0]               wb_data,
   input  logic                                alloc_req,
   output logic                                alloc_ready,
   output logic [TAG_W-1:0]                    alloc_tag,
   input  logic                                resolve_ok,
   input  logic                                resolve_bad,
   output logic                                restore_valid,
   output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] restore_regs,
   output logic [TAG_W-1:0]                    restore_tag,
   output logic [TAG_W:0]                      count,
   output logic                                full,
   output logic                                empty,
   output logic                                err
);

   localparam logic [TAG_W:0]   COUNT_MAX = (TAG_W+1)'(NUM_CKPT);
   localparam logic [TAG_W:0]   COUNT_ONE = (TAG_W+1)'(1);
   localparam logic [TAG_W-1:0] PTR_ONE   = TAG_W'(1);

   typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] image_t;

   // Snapshot storage: one full register image per entry, written whole
   // and read whole into a registered output.
   image_t mem [NUM_CKPT];

   image_t           snapshot;
   logic [TAG_W-1:0] head_reg, head_next;
   logic [TAG_W-1:0] tail_reg, tail_next;
   logic [TAG_W:0]   count_reg, count_next;
   logic             restore_valid_reg;
   logic [TAG_W-1:0] restore_tag_reg;
   image_t           restore_regs_reg;
   logic             err_reg, err_next;

   logic full_w, empty_w;
   logic do_alloc, do_ok, do_bad;

   assign full_w  = (count_reg == COUNT_MAX);
   assign empty_w = (count_reg == '0);

   // Snapshot image. The same-cycle writeback overrides the register file
   // value, and register 0 is forced to zero last, so a writeback aimed at
   // r0 can never leak into a stored image.
   always_comb begin
      snapshot = regs_in;
      if (wb_en) begin
         snapshot[wb_addr] = wb_data;
      end
      snapshot[0] = '0;
   end

   // Accept / error decode.
   // A misprediction takes priority over everything else in the same
   // cycle:
   //   - a coincident allocation is silently dropped, because it belongs
   //     to the squashed path;
   //   - a coincident resolve_ok is contradictory, so it is flagged.
   // Acceptance of an allocation depends only on the registered count,
   // so alloc_ready never depends on resolve_ok in the same cycle.
   always_comb begin
      do_bad   = resolve_bad && !empty_w;
      do_alloc = alloc_req && !full_w && !resolve_bad;
      do_ok    = resolve_ok && !empty_w && !resolve_bad;

      err_next = (alloc_req && full_w && !resolve_bad)
              || (resolve_ok && (empty_w || resolve_bad))
              || (resolve_bad && empty_w);

      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;

      if (do_bad) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (do_alloc) begin
            tail_next = tail_reg + PTR_ONE;
         end
         if (do_ok) begin
            head_next = head_reg + PTR_ONE;
         end
         case ({do_alloc, do_ok})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
         endcase
      end
   end

   // Control state and restore output registers.
   // The restore read uses the pre-flush head, so the image returned is
   // the one belonging to the mispredicted (oldest) branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg          <= '0;
         tail_reg          <= '0;
         count_reg         <= '0;
         restore_valid_reg <= 1'b0;
         restore_tag_reg   <= '0;
         restore_regs_reg  <= '0;
         err_reg           <= 1'b0;
      end else begin
         head_reg          <= head_next;
         tail_reg          <= tail_next;
         count_reg         <= count_next;
         restore_valid_reg <= do_bad;
         err_reg           <= err_next;
         if (do_bad) begin
            restore_tag_reg  <= head_reg;
            restore_regs_reg <= mem[head_reg];
         end
      end
   end

   // Storage write. This is not reset; entries are only ever read after
   // they have been written by an accepted allocation.
   always_ff @(posedge clk) begin
      if (!rst && do_alloc) begin
         mem[tail_reg] <= snapshot;
      end
   end

   assign alloc_ready   = !full_w;
   assign alloc_tag     = tail_reg;
   assign count         = count_reg;
   assign full          = full_w;
   assign empty         = empty_w;
   assign restore_valid = restore_valid_reg;
   assign restore_tag   = restore_tag_reg;
   assign restore_regs  = restore_regs_reg;
   assign err           = err_reg;

endmodule
